// File: rtl/fpu_arb_pkg.sv
// Shared types for the FPU issue arbiter: FSM states, FPU exception flags
// and the opcode / rounding-mode widths used on both sides of the arbiter.
package fpu_arb_pkg;

  localparam int FPU_OP_W = 5;
  localparam int FPU_RM_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Bit order matches the FPU flag bus: {IV,DZ,OF,UF,IE}.
  typedef struct packed {
    logic iv;
    logic dz;
    logic of;
    logic uf;
    logic ie;
  } fpu_flags_t;

endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// Requester, response and FPU-side signals of the issue arbiter. The slave
// modport is the arbiter; master is the surrounding requesters plus the FPU.
interface fpu_issue_arbiter_if
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*FPU_OP_W-1:0] req_op;
  logic [NUM_REQ*FPU_RM_W-1:0] req_rm;
  logic [NUM_REQ*32-1:0]       req_a;
  logic [NUM_REQ*32-1:0]       req_b;
  logic [NUM_REQ*32-1:0]       req_c;
  logic [NUM_REQ*TAG_W-1:0]    req_tag;
  logic [NUM_REQ-1:0]          req_kill;

  logic [NUM_REQ-1:0]          resp_valid;
  logic [NUM_REQ-1:0]          resp_ready;
  logic [31:0]                 resp_result;
  fpu_flags_t                  resp_flags;
  logic [TAG_W-1:0]            resp_tag;

  logic                        fpu_load;
  logic [FPU_OP_W-1:0]         fpu_op;
  logic [FPU_RM_W-1:0]         fpu_rm;
  logic [31:0]                 fpu_a;
  logic [31:0]                 fpu_b;
  logic [31:0]                 fpu_c;
  logic [31:0]                 fpu_result;
  fpu_flags_t                  fpu_flags;
  logic                        fpu_ready;

  logic                        busy;

  modport master (
    output req_valid, req_op, req_rm, req_a, req_b, req_c, req_tag, req_kill,
    output resp_ready, fpu_result, fpu_flags, fpu_ready,
    input  req_ready, resp_valid, resp_result, resp_flags, resp_tag,
    input  fpu_load, fpu_op, fpu_rm, fpu_a, fpu_b, fpu_c, busy
  );

  modport slave (
    input  req_valid, req_op, req_rm, req_a, req_b, req_c, req_tag, req_kill,
    input  resp_ready, fpu_result, fpu_flags, fpu_ready,
    output req_ready, resp_valid, resp_result, resp_flags, resp_tag,
    output fpu_load, fpu_op, fpu_rm, fpu_a, fpu_b, fpu_c, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// after i_ptr, wrapping around to index 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_upper;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
  end

  // Lowest set bit among requests at/after the pointer, else lowest overall.
  assign w_upper = i_req & w_mask;
  assign o_grant = (|w_upper) ? (w_upper & (~w_upper + N'(1)))
                              : (i_req & (~i_req + N'(1)));

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one FPU between NUM_REQ requesters: round-robin accept, one load
// pulse, wait for the FPU, then hold the response until the owner takes it.
module fpu_issue_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  fpu_issue_arbiter_if.slave io_arb
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [PW-1:0]        r_ptr;
  logic [NUM_REQ-1:0]   r_owner;
  logic                 r_killed;

  logic [FPU_OP_W-1:0]  r_op;
  logic [FPU_RM_W-1:0]  r_rm;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [31:0]          r_c;
  logic [TAG_W-1:0]     r_tag;
  logic [31:0]          r_result;
  fpu_flags_t           r_flags;

  logic [NUM_REQ-1:0]   w_grant;
  logic [PW-1:0]        w_grant_idx;
  logic [FPU_OP_W-1:0]  w_sel_op;
  logic [FPU_RM_W-1:0]  w_sel_rm;
  logic [31:0]          w_sel_a;
  logic [31:0]          w_sel_b;
  logic [31:0]          w_sel_c;
  logic [TAG_W-1:0]     w_sel_tag;
  logic                 w_accept;
  logic                 w_kill_owner;
  logic                 w_kill_now;
  logic                 w_take_owner;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .i_req   (io_arb.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Mux the granted requester's fields with constant slice bases.
  always_comb begin
    w_grant_idx = '0;
    w_sel_op    = '0;
    w_sel_rm    = '0;
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_sel_c     = '0;
    w_sel_tag   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_idx = PW'(i);
        w_sel_op    = io_arb.req_op[i*FPU_OP_W +: FPU_OP_W];
        w_sel_rm    = io_arb.req_rm[i*FPU_RM_W +: FPU_RM_W];
        w_sel_a     = io_arb.req_a[i*32 +: 32];
        w_sel_b     = io_arb.req_b[i*32 +: 32];
        w_sel_c     = io_arb.req_c[i*32 +: 32];
        w_sel_tag   = io_arb.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign w_kill_owner = |(io_arb.req_kill & r_owner);
  assign w_take_owner = |(io_arb.resp_ready & r_owner);
  // A kill arriving in the same cycle as fpu_ready still discards the result.
  assign w_kill_now   = r_killed | w_kill_owner;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|io_arb.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (io_arb.fpu_ready) begin
          w_state_nxt = w_kill_now ? IDLE : RESP;
        end
      end
      RESP: begin
        if (w_kill_owner || w_take_owner) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: operand/response registers are reset too, because they drive output buses that must read 0 in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_killed <= 1'b0;
      r_op     <= '0;
      r_rm     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant;
        r_killed <= 1'b0;
        r_op     <= w_sel_op;
        r_rm     <= w_sel_rm;
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_c      <= w_sel_c;
        r_tag    <= w_sel_tag;
        if (w_grant_idx == PW'(NUM_REQ - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_grant_idx + PW'(1);
        end
      end
      if (r_state == WAIT) begin
        r_killed <= w_kill_now;
        if (io_arb.fpu_ready && !w_kill_now) begin
          r_result <= io_arb.fpu_result;
          r_flags  <= io_arb.fpu_flags;
        end
      end
    end
  end

  // req_ready is gated by reset so it reads 0 even with requests pending.
  assign io_arb.req_ready   = w_grant & {NUM_REQ{(r_state == IDLE) && !reset}};
  assign io_arb.resp_valid  = r_owner & {NUM_REQ{r_state == RESP}};
  assign io_arb.resp_result = r_result;
  assign io_arb.resp_flags  = r_flags;
  assign io_arb.resp_tag    = r_tag;
  assign io_arb.fpu_load    = (r_state == ISSUE);
  assign io_arb.fpu_op      = r_op;
  assign io_arb.fpu_rm      = r_rm;
  assign io_arb.fpu_a       = r_a;
  assign io_arb.fpu_b       = r_b;
  assign io_arb.fpu_c       = r_c;
  assign io_arb.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter with a fixed-latency FPU model that
// counts overlapping loads; all expected values are hand-computed constants.
module tb_fpu_issue_arbiter;
  import fpu_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  int          fpu_lat      = 3;
  logic [31:0] cfg_result   = '0;
  logic [4:0]  cfg_flags    = '0;
  int          load_overlap = 0;

  always #5 clk = ~clk;

  fpu_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  fpu_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_arb (bus)
  );

  // FPU model: ready fpu_lat cycles after a load; garbage on the buses otherwise.
  initial begin
    bit fpu_pend;
    int fpu_cnt;
    fpu_pend = 1'b0;
    fpu_cnt  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.fpu_ready  = 1'b0;
        bus.fpu_result = '0;
        bus.fpu_flags  = '0;
        fpu_pend       = 1'b0;
        fpu_cnt        = 0;
      end else begin
        bus.fpu_ready  = 1'b0;
        bus.fpu_result = 32'hDEADBEEF;
        bus.fpu_flags  = '1;
        if (bus.fpu_load) begin
          if (fpu_pend) load_overlap++;
          fpu_pend = 1'b1;
          fpu_cnt  = fpu_lat;
        end else if (fpu_pend) begin
          fpu_cnt--;
          if (fpu_cnt == 0) begin
            bus.fpu_ready  = 1'b1;
            bus.fpu_result = cfg_result;
            bus.fpu_flags  = cfg_flags;
            fpu_pend       = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.req_op[i*5 +: 5]          = op;
    bus.req_rm[i*3 +: 3]          = 3'd0;
    bus.req_a[i*32 +: 32]         = a;
    bus.req_b[i*32 +: 32]         = b;
    bus.req_c[i*32 +: 32]         = 32'h0;
    bus.req_tag[i*TAG_W +: TAG_W] = tag;
    bus.req_valid[i]              = 1'b1;
  endtask

  // Returns at the ISSUE cycle (fpu_load visible).
  task automatic grant(input int i, input string tag, input bit drop);
    int n;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      step();
      n++;
    end
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(oh(i)));
    step();
    if (drop) bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input string tag, output int cyc);
    cyc = 0;
    while (bus.resp_valid == '0 && cyc < 30) begin
      step();
      cyc++;
    end
    check({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'(oh(i)));
  endtask

  task automatic take(input int i, input string tag);
    bus.resp_ready[i] = 1'b1;
    step();
    bus.resp_ready[i] = 1'b0;
    check({tag, ".resp_done"}, 64'({bus.resp_valid, bus.busy}), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    logic any;

    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_rm     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_c      = '0;
    bus.req_tag    = '0;
    bus.req_kill   = '0;
    bus.resp_ready = '0;

    // Reset state
    step();
    check("rst.ctrl", 64'({bus.req_ready, bus.resp_valid, bus.fpu_load, bus.busy}), 64'(0));
    check("rst.data", 64'({bus.fpu_a, bus.resp_result}), 64'(0));
    step();
    reset = 1'b0;

    // 1: single ADD 1.0 + 2.0 = 3.0
    cfg_result = 32'h40400000;
    cfg_flags  = 5'b00000;
    set_req(0, 5'd0, 32'h3F800000, 32'h40000000, 5'd7);
    grant(0, "t1", 1'b1);
    check("t1.fpu_load", 64'(bus.fpu_load), 64'(1));
    check("t1.fpu_ab", {bus.fpu_a, bus.fpu_b}, {32'h3F800000, 32'h40000000});
    check("t1.issue_ctrl", 64'({bus.fpu_op, bus.busy, bus.req_ready}), 64'({5'd0, 1'b1, 2'b00}));
    step();
    check("t1.load_pulse", 64'(bus.fpu_load), 64'(0));
    wait_resp(0, "t1", cyc);
    check("t1.latency", 64'(cyc), 64'(3));
    check("t1.result", 64'(bus.resp_result), 64'(32'h40400000));
    check("t1.tag_flags", 64'({bus.resp_tag, bus.resp_flags}), 64'({5'd7, 5'b00000}));
    take(0, "t1");

    // 2: both requesters continuously valid -> grants 0,1,0,1 from pointer 0
    do_reset();
    cfg_result = 32'h0000_0AAA;
    set_req(0, 5'd1, 32'h1, 32'h0, 5'd1);
    set_req(1, 5'd2, 32'h2, 32'h0, 5'd2);
    for (int k = 0; k < 4; k++) begin
      int e;
      e = k % 2;
      grant(e, $sformatf("t2.%0d", k), 1'b0);
      check($sformatf("t2.%0d.fpu_a", k), 64'(bus.fpu_a), 64'(e + 1));
      wait_resp(e, $sformatf("t2.%0d", k), cyc);
      check($sformatf("t2.%0d.tag", k), 64'(bus.resp_tag), 64'(e + 1));
      take(e, $sformatf("t2.%0d", k));
    end
    bus.req_valid = '0;
    check("t2.no_overlap", 64'(load_overlap), 64'(0));

    // 3: owner stalls the response for 10 cycles while req0 waits
    cfg_result = 32'h12345678;
    cfg_flags  = 5'b00001;
    set_req(1, 5'd3, 32'h40800000, 32'h0, 5'd9);
    grant(1, "t3", 1'b1);
    set_req(0, 5'd1, 32'h5, 32'h0, 5'd4);
    wait_resp(1, "t3", cyc);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("t3.hold%0d", k),
            64'({bus.resp_result, bus.resp_tag, bus.resp_flags, bus.resp_valid, bus.req_ready, bus.fpu_load}),
            64'({32'h12345678, 5'd9, 5'b00001, 2'b10, 2'b00, 1'b0}));
    end
    take(1, "t3");
    grant(0, "t3b", 1'b1);
    wait_resp(0, "t3b", cyc);
    check("t3b.tag", 64'(bus.resp_tag), 64'(4));
    take(0, "t3b");

    // 4a: kill during WAIT
    cfg_flags = 5'b00000;
    set_req(0, 5'd1, 32'h6, 32'h0, 5'd11);
    grant(0, "t4a", 1'b1);
    step();
    bus.req_kill[0] = 1'b1;
    step();
    bus.req_kill[0] = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 6; k++) begin
      any |= |bus.resp_valid;
      step();
    end
    check("t4a.no_resp", 64'({any, bus.busy}), 64'(0));
    set_req(1, 5'd1, 32'h7, 32'h0, 5'd12);
    grant(1, "t4a.next", 1'b1);
    wait_resp(1, "t4a.next", cyc);
    check("t4a.next.tag", 64'(bus.resp_tag), 64'(12));
    take(1, "t4a.next");

    // 4b: kill in the same cycle as fpu_ready
    set_req(0, 5'd1, 32'h8, 32'h0, 5'd13);
    grant(0, "t4b", 1'b1);
    n = 0;
    while (!bus.fpu_ready && n < 10) begin
      step();
      n++;
    end
    check("t4b.saw_ready", 64'(bus.fpu_ready), 64'(1));
    bus.req_kill[0] = 1'b1;
    step();
    bus.req_kill[0] = 1'b0;
    any = |bus.resp_valid;
    for (int k = 0; k < 4; k++) begin
      step();
      any |= |bus.resp_valid;
    end
    check("t4b.no_resp", 64'({any, bus.busy}), 64'(0));
    set_req(1, 5'd1, 32'h9, 32'h0, 5'd14);
    grant(1, "t4b.next", 1'b1);
    wait_resp(1, "t4b.next", cyc);
    check("t4b.next.tag", 64'(bus.resp_tag), 64'(14));
    take(1, "t4b.next");

    // 5: sqrt(-1) -> canonical NaN with IV
    cfg_result = 32'h7FC00000;
    cfg_flags  = 5'b10000;
    set_req(0, 5'd4, 32'hBF800000, 32'h0, 5'd15);
    grant(0, "t5", 1'b1);
    wait_resp(0, "t5", cyc);
    check("t5.result", 64'(bus.resp_result), 64'(32'h7FC00000));
    check("t5.flags", 64'(bus.resp_flags), 64'(5'b10000));
    take(0, "t5");

    // 6: asynchronous reset while in WAIT, then pointer restarts at 0
    cfg_result = 32'h3F800000;
    cfg_flags  = 5'b00000;
    set_req(1, 5'd1, 32'hA, 32'h0, 5'd16);
    grant(1, "t6", 1'b1);
    step();
    check("t6.in_wait", 64'({bus.busy, bus.fpu_load}), 64'({1'b1, 1'b0}));
    set_req(0, 5'd1, 32'hB, 32'h0, 5'd17);
    set_req(1, 5'd1, 32'hC, 32'h0, 5'd18);
    #1 reset = 1'b1;
    #1;
    check("t6.async_ctrl", 64'({bus.req_ready, bus.resp_valid, bus.fpu_load, bus.busy}), 64'(0));
    check("t6.async_data", 64'({bus.fpu_a, bus.fpu_op, bus.resp_tag, bus.resp_flags}), 64'(0));
    check("t6.async_result", 64'(bus.resp_result), 64'(0));
    step();
    step();
    reset = 1'b0;
    grant(0, "t6.first", 1'b1);
    wait_resp(0, "t6.first", cyc);
    check("t6.first.tag", 64'({bus.resp_tag, bus.resp_result}), 64'({5'd17, 32'h3F800000}));
    take(0, "t6.first");
    grant(1, "t6.second", 1'b1);
    wait_resp(1, "t6.second", cyc);
    check("t6.second.tag", 64'(bus.resp_tag), 64'(18));
    take(1, "t6.second");

    check("end.no_overlap", 64'(load_overlap), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
